// File: rtl/alu_iterative_if.sv
// Request/response bundle for alu_iterative: request side (in_*, alu_sel, operands),
// response side (out_*, result, flags) and the FSM state for observation.
interface alu_iterative_if #(
  parameter int XLEN = 32
);
  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // valid and its payload stay stable until that transfer, ready never depends on valid.
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_sel;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zf;
  logic            cf;
  logic            vf;
  logic            sf;
  logic [1:0]      dbg_state;

  modport master (
    output in_valid, alu_sel, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zf, cf, vf, sf, dbg_state
  );

  modport slave (
    input  in_valid, alu_sel, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zf, cf, vf, sf, dbg_state
  );
endinterface

// File: rtl/alu_iterative.sv
// Execute-stage ALU with valid/ready on both sides; shifts run serially at 1 bit/cycle.
// Define FAST_SHIFT_EN to replace the serial shifter with a single-cycle barrel shifter.
module alu_iterative #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  alu_iterative_if.slave   bus
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_LUI  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1101;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [XLEN-1:0]    res_q;
  logic               zf_q, cf_q, vf_q, sf_q;
  logic               accept;
  logic               go_shift;
  logic [SHAMT_W-1:0] shamt;

  logic [XLEN-1:0]    alu_res;
  logic               alu_cf, alu_vf;
  logic [XLEN-1:0]    b_eff;
  logic [XLEN:0]      sum;
  logic               is_sub;

  assign shamt = bus.op_b[SHAMT_W-1:0];

  always_comb begin
    bus.in_ready = (state == S_IDLE) | ((state == S_DONE) & bus.out_ready);
    accept       = bus.in_valid & bus.in_ready;
  end

  // Single-cycle datapath; SUB is A + ~B + 1 so cf reads as "no borrow".
  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_vf  = 1'b0;
    is_sub  = (bus.alu_sel == OP_SUB);
    b_eff   = is_sub ? ~bus.op_b : bus.op_b;
    sum     = {1'b0, bus.op_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};
    case (bus.alu_sel)
      OP_ADD, OP_SUB: begin
        alu_res = sum[XLEN-1:0];
        alu_cf  = sum[XLEN];
        alu_vf  = (bus.op_a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != bus.op_a[XLEN-1]);
      end
      OP_LUI:  alu_res = bus.op_b;
      OP_OR:   alu_res = bus.op_a | bus.op_b;
      OP_AND:  alu_res = bus.op_a & bus.op_b;
      OP_XOR:  alu_res = bus.op_a ^ bus.op_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
`ifdef FAST_SHIFT_EN
      OP_SLL:  alu_res = bus.op_a << shamt;
      OP_SRL:  alu_res = bus.op_a >> shamt;
      OP_SRA:  alu_res = $signed(bus.op_a) >>> shamt;
`else
      // Only reached for a zero shift amount; non-zero amounts go through S_SHIFT.
      OP_SLL, OP_SRL, OP_SRA: alu_res = bus.op_a;
`endif
      default: alu_res = '0;
    endcase
  end

`ifdef FAST_SHIFT_EN
  assign go_shift = 1'b0;
`else
  localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

  logic [SHAMT_W-1:0] cnt;
  logic [1:0]         shift_sel;
  logic [XLEN-1:0]    shift_nx;

  assign go_shift = ((bus.alu_sel == OP_SLL) || (bus.alu_sel == OP_SRL) ||
                     (bus.alu_sel == OP_SRA)) && (shamt != '0);

  // During SRA the MSB of res_q never changes, so it is the captured A[XLEN-1].
  always_comb begin
    case (shift_sel)
      2'b00:   shift_nx = {res_q[XLEN-2:0], 1'b0};
      2'b01:   shift_nx = {1'b0, res_q[XLEN-1:1]};
      default: shift_nx = {res_q[XLEN-1], res_q[XLEN-1:1]};
    endcase
  end
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nx = go_shift ? S_SHIFT : S_DONE;
      end
`ifndef FAST_SHIFT_EN
      S_SHIFT: begin
        if (cnt == CNT_ONE) state_nx = S_DONE;
      end
`endif
      S_DONE: begin
        if (bus.out_ready) state_nx = accept ? (go_shift ? S_SHIFT : S_DONE) : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      res_q <= '0;
      zf_q  <= 1'b0;
      cf_q  <= 1'b0;
      vf_q  <= 1'b0;
      sf_q  <= 1'b0;
`ifndef FAST_SHIFT_EN
      cnt       <= '0;
      shift_sel <= 2'b00;
`endif
    end else begin
      state <= state_nx;
      if (accept && !go_shift) begin
        res_q <= alu_res;
        zf_q  <= (alu_res == '0);
        cf_q  <= alu_cf;
        vf_q  <= alu_vf;
        sf_q  <= alu_res[XLEN-1];
      end
`ifndef FAST_SHIFT_EN
      else if (accept) begin
        res_q     <= bus.op_a;
        cnt       <= shamt;
        shift_sel <= bus.alu_sel[1:0];
        zf_q      <= 1'b0;
        cf_q      <= 1'b0;
        vf_q      <= 1'b0;
        sf_q      <= 1'b0;
      end else if (state == S_SHIFT) begin
        res_q <= shift_nx;
        cnt   <= cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          zf_q <= (shift_nx == '0);
          sf_q <= shift_nx[XLEN-1];
        end
      end
`endif
    end
  end

  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = res_q;
  assign bus.zf        = zf_q;
  assign bus.cf        = cf_q;
  assign bus.vf        = vf_q;
  assign bus.sf        = sf_q;
  assign bus.dbg_state = state;

endmodule
